// File: rtl/demux_x16_seq.sv
// Sequential 1-to-16 demultiplexer: routes words into 16 lanes and presents them as one frame.
// Optional macro DEMUX_X16_FLUSH_EN adds a flush input to emit a partially filled frame early.
module demux_x16_seq #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sel_mode,
    input  logic [3:0]          in_sel,
    output logic [16*DATA_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         lane_mask,
`ifdef DEMUX_X16_FLUSH_EN
    input  logic                flush,
`endif
    output logic                o_dbg_state
);

    // Handshake: a word moves on in_valid && in_ready, a frame on out_valid && out_ready.
    localparam logic S_FILL = 1'b0;
    localparam logic S_HOLD = 1'b1;

    logic                  r_state;
    logic [3:0]            r_cnt;
    logic [16*DATA_W-1:0]  r_lanes;
    logic [15:0]           r_mask;

    logic                  w_accept;
    logic [3:0]            w_lane;
    logic [15:0]           w_lane_bit;
    logic [15:0]           w_mask_nxt;
    logic                  w_done;
    logic                  w_flush_go;

    assign w_accept   = in_valid && (r_state == S_FILL);
    assign w_lane     = sel_mode ? in_sel : r_cnt;
    assign w_lane_bit = 16'd1 << w_lane;
    assign w_mask_nxt = r_mask | (w_accept ? w_lane_bit : 16'd0);
    assign w_done     = (w_mask_nxt == 16'hFFFF);

`ifdef DEMUX_X16_FLUSH_EN
    // A same-cycle accept counts toward the non-empty check, so it is written before flushing.
    assign w_flush_go = flush && (r_state == S_FILL) && (w_mask_nxt != 16'd0);
`else
    assign w_flush_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_cnt   <= 4'd0;
            r_lanes <= '0;
            r_mask  <= 16'd0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < 16; k++) begin
                            if (w_lane == 4'(k)) begin
                                r_lanes[k*DATA_W +: DATA_W] <= in_data;
                            end
                        end
                        r_mask <= w_mask_nxt;
                        if (!sel_mode) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    if (w_done || w_flush_go) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_FILL;
                        r_cnt   <= 4'd0;
                        r_lanes <= '0;
                        r_mask  <= 16'd0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign in_ready    = (r_state == S_FILL);
    assign out_valid   = (r_state == S_HOLD);
    assign out_data    = r_lanes;
    assign lane_mask   = r_mask;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_demux_x16_seq.sv
// Directed self-checking bench for demux_x16_seq with a frame scoreboard.
module tb_demux_x16_seq;

  localparam int DW = 8;
  localparam int FW = 16 * DW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sel_mode;
  logic [3:0]    in_sel;
  logic [FW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   lane_mask;
  logic          dbg_state;
`ifdef DEMUX_X16_FLUSH_EN
  logic          flush;
`endif

  demux_x16_seq #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel_mode   (sel_mode),
    .in_sel     (in_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lane_mask  (lane_mask),
`ifdef DEMUX_X16_FLUSH_EN
    .flush      (flush),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model
  logic [FW-1:0] exp_q[$];
  logic [15:0]   exp_mask_q[$];
  logic [DW-1:0] m_lanes[16];
  logic [15:0]   m_mask;
  logic [3:0]    m_cnt;
  logic          m_pending;
  int            n_cmp;
  int            n_err;

  function automatic logic [FW-1:0] pack_model();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[k*DW +: DW] = m_lanes[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_lanes[k] = '0;
    m_mask    = 16'd0;
    m_cnt     = 4'd0;
    m_pending = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one word presented for one cycle; returns #1 after the accepting edge
  task automatic send_word(input logic [DW-1:0] d, input logic mode, input logic [3:0] sel);
    logic [3:0] lane;
    @(negedge clk);
    in_data  = d;
    sel_mode = mode;
    in_sel   = sel;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lane = mode ? sel : m_cnt;
    m_lanes[lane] = d;
    m_mask[lane]  = 1'b1;
    if (!mode) m_cnt = m_cnt + 4'd1;
    if (m_mask == 16'hFFFF) begin
      exp_q.push_back(pack_model());
      exp_mask_q.push_back(m_mask);
      m_pending = 1'b1;
    end
    chk("out_valid_after_accept", FW'(out_valid), FW'(m_pending));
    chk("lane_mask_after_accept", FW'(lane_mask), FW'(m_mask));
  endtask

  task automatic expect_frame(input string tag);
    logic [FW-1:0] ef;
    logic [15:0]   em;
    for (int i = 0; i < 5 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_out_valid"}, FW'(out_valid), FW'(1));
    chk({tag, "_in_ready_hold"}, FW'(in_ready), FW'(0));
    chk({tag, "_queue_nonempty"}, FW'(exp_q.size() != 0), FW'(1));
    if (exp_q.size() != 0) begin
      ef = exp_q.pop_front();
      em = exp_mask_q.pop_front();
      chk({tag, "_out_data"}, out_data, ef);
      chk({tag, "_lane_mask"}, FW'(lane_mask), FW'(em));
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    model_clear();
    chk({tag, "_cleared_valid"}, FW'(out_valid), FW'(0));
    chk({tag, "_cleared_mask"}, FW'(lane_mask), FW'(0));
    chk({tag, "_cleared_data"}, out_data, '0);
    chk({tag, "_cleared_ready"}, FW'(in_ready), FW'(1));
  endtask

  logic [FW-1:0] held;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    sel_mode = 1'b0;
    in_sel = 4'd0;
    out_ready = 1'b0;
`ifdef DEMUX_X16_FLUSH_EN
    flush = 1'b0;
`endif
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", FW'(out_valid), FW'(0));
    chk("reset_lane_mask", FW'(lane_mask), FW'(0));
    chk("reset_out_data", out_data, '0);
    chk("reset_state", FW'(dbg_state), FW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", FW'(in_ready), FW'(1));

    // auto fill with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_word(8'h10 + 8'(k), 1'b0, 4'd0);
    expect_frame("auto");
    out_ready = 1'b0;
    consume("auto");

    // addressed reverse fill, lane 3 rewritten before completion
    for (int s = 15; s >= 4; s--) send_word(8'(s), 1'b1, 4'(s));
    send_word(8'h03, 1'b1, 4'd3);
    send_word(8'hAA, 1'b1, 4'd3);
    for (int s = 2; s >= 0; s--) send_word(8'(s), 1'b1, 4'(s));
    chk("addr_lane3", FW'(out_data[3*DW +: DW]), FW'(8'hAA));
    expect_frame("addr");

    // backpressure in HOLD with input pressure
    held = out_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      sel_mode = 1'($urandom_range(0, 1));
      in_sel   = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      chk("bp_in_ready", FW'(in_ready), FW'(0));
      chk("bp_out_data", out_data, held);
      chk("bp_lane_mask", FW'(lane_mask), FW'(16'hFFFF));
    end
    in_valid = 1'b0;
    consume("addr");

    // reset mid fill discards the partial frame
    for (int k = 0; k < 7; k++) send_word(8'h50 + 8'(k), 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", FW'(out_valid), FW'(0));
    chk("midrst_lane_mask", FW'(lane_mask), FW'(0));
    chk("midrst_out_data", out_data, '0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) send_word(8'($urandom_range(0, 255)), 1'b0, 4'd0);
    expect_frame("post_rst");
    consume("post_rst");

    // mode switch mid frame
    for (int k = 0; k < 4; k++) send_word(8'hC0 + 8'(k), 1'b0, 4'd0);
    for (int s = 4; s < 16; s++) send_word(8'hD0 + 8'(s), 1'b1, 4'(s));
    expect_frame("mode_sw");
    consume("mode_sw");

`ifdef DEMUX_X16_FLUSH_EN
    // flush with empty mask is ignored
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_empty_ignored", FW'(out_valid), FW'(0));
    for (int k = 0; k < 5; k++) send_word(8'hA0 + 8'(k), 1'b0, 4'd0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.push_back(pack_model());
    exp_mask_q.push_back(16'h001F);
    expect_frame("flush");
    consume("flush");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_x16_seq.md
DEMUX_X16_SEQ -- requirements
Module: demux_x16_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one lane word.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  in  DATA_W  word to be routed to one lane.
REQ-005 SHALL have port in_valid  in  1  in_data/in_sel valid.
REQ-006 SHALL have port in_ready  out  1  block accepts a word this cycle.
REQ-007 SHALL have port sel_mode  in  1  0 = auto-sequence lanes 0..15, 1 = addressed via in_sel.
REQ-008 SHALL have port in_sel  in  4  target lane when sel_mode=1; ignored otherwise.
REQ-009 SHALL have port out_data  out  16*DATA_W  frame; lane k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  out  1  complete frame held on out_data.
REQ-011 SHALL have port out_ready  in  1  downstream consumes frame.
REQ-012 SHALL have port lane_mask  out  16  bit k set once lane k written in current frame.

Function
REQ-013 SHALL implement two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a word only on in_valid && in_ready.
REQ-015 SHALL, in auto mode, write an accepted word to lane cnt, set lane_mask[cnt], increment the 4-bit cnt.
REQ-016 SHALL, in addressed mode, write an accepted word to lane in_sel, set lane_mask[in_sel]; cnt unchanged; rewriting a lane overwrites data, mask unchanged.
REQ-017 SHALL move FILL->HOLD on the cycle after the accept that makes lane_mask 16'hFFFF.
REQ-018 SHALL, in HOLD, keep out_data and lane_mask stable until out_valid && out_ready.
REQ-019 SHALL, on out_valid && out_ready, go to HOLD->FILL next cycle with all lanes, lane_mask and cnt cleared to 0.
REQ-020 SHALL NOT accept input in the handoff cycle (in_ready=0 throughout HOLD); no same-cycle bypass.
REQ-021 SHALL sample sel_mode per accepted word; a mid-frame switch keeps cnt and lane_mask, and completion still requires lane_mask all ones.
REQ-022 SHALL wrap cnt 15->0 modulo 16; in auto mode the wrap coincides with frame completion.
REQ-023 SHALL give latency from final accept to out_valid of exactly one cycle.
REQ-024 SHALL drive out_data as direct register outputs; no combinational path from inputs to outputs except none (in_ready depends only on state).

Reset
REQ-025 SHALL, on rst_n low, immediately force state=FILL, cnt=0, all lanes=0, lane_mask=0, out_valid=0, in_ready=1 after release.
REQ-026 SHALL discard a partial frame or held frame when reset asserts mid-operation; no frame emitted.

Configuration
REQ-027 SHALL support macro DEMUX_X16_FLUSH_EN; when defined, adds input flush (1 bit): in FILL with lane_mask nonzero, flush forces HOLD next cycle with unwritten lanes at 0; a word accepted in the same cycle is written first; flush with lane_mask=0 and no accept is ignored; flush in HOLD ignored.
REQ-028 SHALL, without DEMUX_X16_FLUSH_EN, have no flush port and emit frames only per REQ-017.

Verification
REQ-029 SHALL cover auto fill: 16 accepts with data 8'h10..8'h1F, out_ready=1 -> out_valid one cycle after last accept, lane k = 8'h10+k, lane_mask=16'hFFFF, then all cleared.
REQ-030 SHALL cover addressed fill in reverse order in_sel=15..0 with data=in_sel, lane 3 written twice (8'h03 then 8'hAA) -> frame valid only after all 16 lanes, lane 3 = 8'hAA.
REQ-031 SHALL cover backpressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, out_data stable, no word accepted.
REQ-032 SHALL cover reset mid-fill: 7 accepts, rst_n low -> out_valid=0, lane_mask=0, cnt=0 immediately; next 16 accepts form a clean frame.
REQ-033 SHALL cover flush (DEMUX_X16_FLUSH_EN): auto-accept 5 words 8'hA0..8'hA4, assert flush -> out_valid next cycle, lanes 0..4 = 8'hA0..8'hA4, lanes 5..15 = 0, lane_mask=16'h001F.
REQ-034 SHALL cover mode switch: 4 auto accepts, then addressed lanes 4..15 -> single complete frame, lane_mask=16'hFFFF.
